// File: rtl/vol_ramp_ctrl.sv
// Per-slot gain slew controller feeding the mixer vol_i bus; gains step toward targets once per frame.
// Optional automute of unlocked channels is enabled by defining VOL_RAMP_AUTOMUTE_EN.
module vol_ramp_ctrl #(
  parameter int NUM_CH    = 1,
  parameter int RAMP_STEP = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_i,
  input  logic [NUM_CH-1:0]       locked_i,
  input  logic                    wr_en_i,
  input  logic [7:0]              wr_addr_i,
  input  logic [15:0]             wr_data_i,
  output logic                    wr_ack_o,
  output logic [NUM_CH*2*16-1:0]  vol_o,
  output logic                    busy_o
);

  localparam int NS = 2 * NUM_CH;
  localparam int AW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [15:0] STEP = 16'(RAMP_STEP);
  localparam logic [AW-1:0] LAST_IDX = AW'(NS - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_UPDATE = 1'b1} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic            r_pending;
  logic            r_busy;
  logic            r_ack;
  logic [15:0]     r_tgt [0:NS-1];
  logic [15:0]     r_cur [0:NS-1];

  logic [15:0]     w_eff [0:NS-1];
  logic [15:0]     w_next;
  logic            w_busy_next;

  // Difference is taken before stepping, so the result never wraps and lands exactly on the target.
  function automatic logic [15:0] f_step(input logic [15:0] cur, input logic [15:0] eff);
    logic [15:0] diff;
    if (cur < eff) begin
      diff = eff - cur;
      return (diff > STEP) ? (cur + STEP) : eff;
    end else if (cur > eff) begin
      diff = cur - eff;
      return (diff > STEP) ? (cur - STEP) : eff;
    end else begin
      return cur;
    end
  endfunction

  // Effective target per slot
  always_comb begin
    for (int k = 0; k < NS; k++) begin
`ifdef VOL_RAMP_AUTOMUTE_EN
      w_eff[k] = locked_i[k/2] ? r_tgt[k] : 16'd0;
`else
      w_eff[k] = r_tgt[k];
`endif
    end
  end

`ifndef VOL_RAMP_AUTOMUTE_EN
  logic w_unused_locked;
  assign w_unused_locked = ^locked_i;
`endif

  // Next value of the slot being processed and end-of-pass busy on post-update values
  always_comb begin
    w_next      = f_step(r_cur[r_idx], w_eff[r_idx]);
    w_busy_next = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (AW'(k) == r_idx) begin
        w_busy_next = w_busy_next | (w_next != w_eff[k]);
      end else begin
        w_busy_next = w_busy_next | (r_cur[k] != w_eff[k]);
      end
    end
  end

  // Register port, frame sequencing and slot update FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        r_tgt[i] <= 16'd0;
        r_cur[i] <= 16'd0;
      end
    end else begin
      r_ack <= wr_en_i;
      if (wr_en_i && (int'(wr_addr_i) < NS)) begin
        r_tgt[wr_addr_i[AW-1:0]] <= wr_data_i;
      end
      case (r_state)
        ST_IDLE: begin
          if (frame_i) begin
            r_state <= ST_UPDATE;
            r_idx   <= '0;
          end
        end
        ST_UPDATE: begin
          r_cur[r_idx] <= w_next;
          if (r_idx == LAST_IDX) begin
            r_busy <= w_busy_next;
            r_idx  <= '0;
            // A frame landing on the last slot restarts at once; a queued one is consumed first.
            if (r_pending || frame_i) begin
              r_pending <= r_pending & frame_i;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_idx <= r_idx + AW'(1);
            if (frame_i) begin
              r_pending <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NS; g++) begin : g_vol
      assign vol_o[16*g +: 16] = r_cur[g];
    end
  endgenerate

  assign wr_ack_o = r_ack;
  assign busy_o   = r_busy;

endmodule

// File: tb/tb_vol_ramp_ctrl.sv
// Directed self-checking bench for vol_ramp_ctrl with NUM_CH=1, RAMP_STEP=16.
module tb_vol_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_i;
  logic [0:0]  locked_i;
  logic        wr_en_i;
  logic [7:0]  wr_addr_i;
  logic [15:0] wr_data_i;
  logic        wr_ack_o;
  logic [31:0] vol_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  vol_ramp_ctrl #(.NUM_CH(1), .RAMP_STEP(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_i   (frame_i),
    .locked_i  (locked_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .wr_ack_o  (wr_ack_o),
    .vol_o     (vol_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse frame_i for one cycle, then wait until the whole pass and busy are visible.
  task automatic frame();
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic write(input logic [7:0] addr, input logic [15:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = addr;
    wr_data_i = data;
    tick();
    wr_en_i = 1'b0;
    chk("wr_ack", {31'd0, wr_ack_o}, 32'd1);
    tick();
  endtask

  initial begin
    logic [15:0] e;
    rst = 1'b0; frame_i = 1'b0; locked_i = 1'b1;
    wr_en_i = 1'b0; wr_addr_i = 8'd0; wr_data_i = 16'd0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_vol", vol_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ack", {31'd0, wr_ack_o}, 32'd0);
    for (int i = 0; i < 5; i++) frame();
    chk("idle_frames_vol", vol_o, 32'd0);
    chk("idle_frames_busy", {31'd0, busy_o}, 32'd0);

    // Up-ramp to 0x00FF
    write(8'd0, 16'h00FF);
    for (int i = 1; i <= 16; i++) begin
      frame();
      e = (i < 16) ? 16'(16 * i) : 16'h00FF;
      chk("up_vol", vol_o, {16'd0, e});
      chk("up_busy", {31'd0, busy_o}, (i < 16) ? 32'd1 : 32'd0);
    end

    // Down-ramp with clamp at 0x0005
    write(8'd0, 16'h0005);
    for (int i = 1; i <= 16; i++) begin
      frame();
      e = (i < 16) ? 16'(255 - 16 * i) : 16'h0005;
      chk("down_vol", vol_o, {16'd0, e});
    end
    chk("down_busy", {31'd0, busy_o}, 32'd0);
    frame();
    chk("down_hold", vol_o, 32'h0000_0005);
    write(8'd7, 16'h1234);
    frame();
    chk("bad_addr_vol", vol_o, 32'h0000_0005);

    // Both slots to 0x0040, then lock loss / relock
    write(8'd0, 16'h0040);
    write(8'd1, 16'h0040);
    for (int i = 0; i < 3; i++) frame();
    chk("pre_mute_partial", vol_o, 32'h0030_0035);
    frame();
    chk("pre_mute", vol_o, 32'h0040_0040);
    locked_i = 1'b0;
    for (int i = 0; i < 4; i++) frame();
`ifdef VOL_RAMP_AUTOMUTE_EN
    chk("muted", vol_o, 32'h0000_0000);
`else
    chk("not_muted", vol_o, 32'h0040_0040);
`endif
    locked_i = 1'b1;
    for (int i = 0; i < 4; i++) frame();
    chk("relock", vol_o, 32'h0040_0040);
    chk("relock_busy", {31'd0, busy_o}, 32'd0);

    // Frame at t and t+1, write slot 0 in t+1
    frame_i = 1'b1;
    tick();
    wr_en_i = 1'b1; wr_addr_i = 8'd0; wr_data_i = 16'h0100;
    tick();
    frame_i = 1'b0; wr_en_i = 1'b0;
    chk("coll_ack", {31'd0, wr_ack_o}, 32'd1);
    chk("coll_pass1_slot0", vol_o, 32'h0040_0040);
    tick();
    chk("coll_busy", {31'd0, busy_o}, 32'd1);
    tick();
    chk("coll_pass2_slot0", vol_o, 32'h0040_0050);
    tick();
    tick();
    chk("coll_no_extra_pass", vol_o, 32'h0040_0050);
    frame();
    chk("coll_next_frame", vol_o, 32'h0040_0060);

    // Reset in the middle of a pass (idx=1)
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
    tick();
    chk("mid_pre_busy", {31'd0, busy_o}, 32'd1);
    chk("mid_pre_vol", vol_o, 32'h0040_0070);
    rst = 1'b0;
    #1;
    chk("mid_rst_vol", vol_o, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_ack", {31'd0, wr_ack_o}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    frame();
    chk("post_rst_vol", vol_o, 32'd0);
    chk("post_rst_busy", {31'd0, busy_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vol_ramp_ctrl.md
# vol_ramp_ctrl

Volume configuration controller for the mixer's `vol_i` bus. Holds per-channel, per-side target gains written over a simple register port. Slews the gains actually presented to the mixer toward their targets by a bounded step once per output frame, which avoids zipper noise. Optionally forces a channel to ramp to silence while its S/PDIF receiver is unlocked. Sits in the clk245760 domain between the config front end (SPI config, later) and `mixer`.

## Interface

**Parameters**
- `NUM_CH`, 1: number of stereo input channels; gain slots = 2*NUM_CH.
- `RAMP_STEP`, 16: maximum gain change per slot per frame; range 1..65535.

**Ports**
- `clk` in 1: mixer clock (245.76 MHz domain).
- `rst` in 1: asynchronous, active-low reset.
- `frame_i` in 1: one-cycle pulse, one per output sample pair (driven from mixer right-side ack).
- `locked_i` in NUM_CH: per-channel DAI lock, already synchronous to `clk`.
- `wr_en_i` in 1: register write strobe, one cycle.
- `wr_addr_i` in 8: slot index = 2*ch + side (side 0 = left, 1 = right).
- `wr_data_i` in 16: target gain, unsigned.
- `wr_ack_o` out 1: one-cycle write acknowledge.
- `vol_o` out NUM_CH*2*16: current gains; slot k occupies bits [16k+15:16k]; connects to mixer `vol_i`.
- `busy_o` out 1: at least one slot had not reached its effective target at the end of the last pass.

## Operation

- **Storage:** `tgt[k]` and `cur[k]` per slot, both 16-bit unsigned. `vol_o` is driven directly from the `cur` registers.
- **Effective target:** `eff[k]` = `tgt[k]`; with automute enabled, `eff[k]` = 0 when `locked_i[k/2]` = 0.
- **FSM states:** IDLE, UPDATE.
  - IDLE → UPDATE on `frame_i`; index `idx` = 0.
  - In UPDATE, one slot is processed per cycle:
    - if `cur` < `eff`: `cur` = (`eff`-`cur` > RAMP_STEP) ? `cur`+RAMP_STEP : `eff`.
    - if `cur` > `eff`: the symmetric decrement.
    - if equal: hold.
  - Differences are computed before adding, so there is no overflow or wrap. Clamping is exact at the target.
  - After slot 2*NUM_CH-1: `busy_o` is set to OR(`cur` != `eff`) evaluated on post-update values. Then go to IDLE, or restart UPDATE at `idx` 0 if `pending` is set, clearing `pending`.
- **Frames during UPDATE:** `frame_i` sets `pending`. A further `frame_i` while `pending` is already set is dropped.
- **Writes:** accepted in any state, any cycle.
  - `tgt[wr_addr_i]` is updated at the clock edge; `wr_ack_o` pulses the following cycle.
  - `wr_addr_i` >= 2*NUM_CH: acknowledged, no state change.
  - Back-to-back writes are allowed, one per cycle.
- **Write/update collision:** a write to slot k in the same cycle UPDATE processes slot k is not seen by that update (old `tgt` used). It takes effect on the next pass.
- **Reset (any time, including mid-pass):** all `tgt`, `cur`, `vol_o` = 0; `busy_o` = 0; `wr_ack_o` = 0; `pending` = 0; state IDLE. The design therefore powers up muted.

## Timing

- `frame_i` at cycle t → slot k is updated at the edge ending cycle t+1+k → visible on `vol_o` from cycle t+2+k.
- A pass takes 2*NUM_CH cycles. `busy_o` is valid from cycle t+2+2*NUM_CH.
- Requirement: frame period > 2*NUM_CH+1 cycles. A frame period is 1280 cycles at 192 kHz, so this is never violated in normal use.
- Write latency: `wr_en_i` at cycle t → `tgt` updated at end of t; `wr_ack_o` high in cycle t+1.
- Full ramp 0→0xFFFF at RAMP_STEP=16 takes 4096 frames.

## Configuration

- `VOL_RAMP_AUTOMUTE_EN` defined:
  - Unlocked channels have `eff` = 0 on both slots, so they ramp down at RAMP_STEP per frame.
  - On relock they ramp back to `tgt`.
  - `tgt` is untouched throughout.
- Not defined: `locked_i` is ignored (may be left unconnected) and `eff` = `tgt` always.

## Test plan

All scenarios use NUM_CH=1 and RAMP_STEP=16.

- **Reset:** assert `rst`=0 for 3 cycles, release → `vol_o`=0, `busy_o`=0, `wr_ack_o`=0. Then 5 `frame_i` pulses → `vol_o` stays 0.
- **Up-ramp:** write slot 0 = 0x00FF; `wr_ack_o` follows 1 cycle later. Apply 16 frames → `vol_o[15:0]` steps 0x10, 0x20 … 0xF0, then 0xFF on frame 16. `busy_o`=1 after frames 1–15 and 0 after frame 16. `vol_o[31:16]` stays 0.
- **Down-ramp / clamp:** from 0x00FF write 0x0005 → `vol_o[15:0]` steps 0xEF, 0xDF … 0x0F, then 0x05 and holds. A write to addr 7 is acked with no change.
- **Automute (macro defined):** both slots at 0x0040, drop `locked_i`=0 → both reach 0 after 4 frames, `tgt` unchanged. Raise `locked_i` → both return to 0x0040 after 4 frames. With the macro undefined, the gains stay at 0x0040.
- **Frame/write collision:** `frame_i` in cycle t and again in t+1 → second pass starts at t+3, no tick lost. A write to slot 0 in cycle t+1 with new value 0x0100 applies from the second pass only.
- **Mid-ramp reset:** assert `rst` during UPDATE with `idx`=1 → all outputs 0 immediately, FSM IDLE. The next `frame_i` produces no change until a new write.
